// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// pipe_skid_reg
//   Pipeline stage register with valid/ready handshake, one-entry skid
//   buffer (registered upstream ready), hold and synchronous flush.
//   Revision: 1.0
// ============================================================================
module pipe_skid_reg #(
  parameter int WIDTH             = 300,
  parameter bit FLUSH_CLEARS_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             emit;

  // Ready is a function of registered state and hold only, never of out_ready.
  assign in_ready  = !hold && (state_q != S_FULL);
  assign out_valid = !hold && (state_q != S_EMPTY);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  assign out_data  = main_q;
  assign occupancy = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
      if (FLUSH_CLEARS_DATA) begin
        main_d = '0;
        skid_d = '0;
      end
    end else if (!hold) begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d = S_ONE;
            main_d  = in_data;
          end
        end
        S_ONE: begin
          if (accept && emit) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = S_FULL;
            skid_d  = in_data;
          end else if (emit) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (emit) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised pipeline stage register, successor to the plain enable/flush stage latch. Adds a valid/ready handshake, a one-entry skid buffer so upstream ready is fully registered, an explicit hold, and a synchronous flush. Sits between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) to carry the bundled stage payload.

Parameters:
WIDTH, 300, payload width in bits
FLUSH_CLEARS_DATA, 1, 1 = flush also zeroes main/skid data registers; 0 = data retained, only valid state cleared

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous kill of stage contents
hold  input  1  freeze stage: no accept, no emit
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat
in_data  input  WIDTH  upstream payload
out_valid  output  1  main register holds a valid beat
out_ready  input  1  downstream accepts beat
out_data  output  WIDTH  payload of main register
occupancy  output  2  number of held beats, 0..2

Behaviour:
- Storage: main register (drives out_data) and skid register; state EMPTY(0), ONE(1), FULL(2); occupancy = state encoding.
- rst asserted (async): state=EMPTY, main=0, skid=0; out_valid=0, occupancy=0, out_data=0, in_ready=1 once hold=0.
- in_ready = !hold && state!=FULL (depends only on state and hold; no combinational path from out_ready).
- out_valid = !hold && state!=EMPTY.
- accept = in_valid && in_ready; emit = out_valid && out_ready.
- Latency: beat accepted in cycle N appears on out_data/out_valid in cycle N+1 when stage was EMPTY or emitting.
- Transitions (flush=0):
  - EMPTY: accept -> ONE, main<=in_data.
  - ONE: accept&emit -> ONE, main<=in_data; accept&!emit -> FULL, skid<=in_data; !accept&emit -> EMPTY; else stay.
  - FULL: accept impossible; emit -> ONE, main<=skid; else stay.
- Ordering: beats leave strictly in acceptance order; no beat duplicated or lost without flush.
- hold=1: in_ready=0, out_valid=0, no state or data change; hold overrides in_valid/out_ready; contents reappear unchanged when hold drops.
- flush=1 (priority over hold and handshakes): next state EMPTY; if FLUSH_CLEARS_DATA, main and skid <=0, else data unchanged. Beat handshaked upstream in the flush cycle is discarded (flush kills the producing stage too); beat emitted downstream in flush cycle counts as delivered (downstream is responsible for its own flush).
- flush and hold both 1: flush wins.
- EMPTY, no flush: out_data holds last main value (0 after reset or clearing flush).
- rst mid-operation: immediate clear regardless of state/flush/hold; deassertion resumes from EMPTY.
- Pure register outputs except in_ready/out_valid (single gate from state and hold).

Test Plan:
- Reset: rst=1 with in_valid=1, in_data=0x5A -> out_valid=0, out_data=0, occupancy=0; after release next cycle in_ready=1.
- Streaming: out_ready=1, push 0x01,0x02,0x03 back-to-back -> out_data 0x01,0x02,0x03 one cycle later each, occupancy stays 1, in_ready never drops.
- Backpressure/skid: out_ready=0, push 0xA1 then 0xA2 -> occupancy=2, in_ready=0, out_data=0xA1; raise out_ready -> 0xA1 then 0xA2 emitted, occupancy 2->1->0, in_ready=1 after first emit.
- Hold: occupancy=1 with 0x77, hold=1 for 3 cycles with in_valid=1, out_ready=1 -> in_ready=0, out_valid=0, occupancy=1; hold=0 -> out_data=0x77 emitted, no new beat taken during hold.
- Flush: FULL with 0xB1/0xB2, flush=1 with in_valid=1 in_data=0xB3 -> next cycle occupancy=0, out_valid=0, out_data=0 (FLUSH_CLEARS_DATA=1); 0xB3 never emitted; repeat with FLUSH_CLEARS_DATA=0 -> out_data stays 0xB1, out_valid=0.
- Flush+hold and async reset mid-FULL: flush=1, hold=1 -> EMPTY; rst pulse mid-clock while FULL -> outputs cleared before next edge.
